// File: rtl/param_stack.sv
// LIFO stack of DEPTH words with registered read port, peek, combined push/pop
// replace, and sticky overflow/underflow flags.
module param_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           din,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       tos,
   input  logic                       err_clr,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_vld,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       ovf,
   output logic                       unf
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] dout_r;
   logic             dout_vld_r;
   logic             ovf_r;
   logic             unf_r;

   logic             empty_s;
   logic             full_s;
   logic [CW-1:0]    cm1_s;
   logic [AW-1:0]    top_idx_s;
   logic [AW-1:0]    wr_idx_s;
   logic             wr_en_s;
   logic             rd_en_s;
   logic [CW-1:0]    count_nxt_s;
   logic             ovf_set_s;
   logic             unf_set_s;
   logic [WIDTH-1:0] rd_data_s;

   assign empty_s   = (count_r == CW'(0));
   assign full_s    = (count_r == CW'(DEPTH));
   // count-1 is only used when not empty, so it always fits in AW bits
   assign cm1_s     = count_r - CW'(1);
   assign top_idx_s = cm1_s[AW-1:0];
   assign rd_data_s = mem_r[top_idx_s];

   // Command decode: push/pop take priority, tos only acts when both are low
   always_comb begin
      wr_en_s     = 1'b0;
      rd_en_s     = 1'b0;
      wr_idx_s    = count_r[AW-1:0];
      count_nxt_s = count_r;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      case ({push, pop})
         2'b11: begin
            wr_en_s = 1'b1;
            if (empty_s) begin
               count_nxt_s = count_r + CW'(1);
            end else begin
               rd_en_s  = 1'b1;
               wr_idx_s = top_idx_s;
            end
         end
         2'b10: begin
            if (full_s) begin
               ovf_set_s = 1'b1;
            end else begin
               wr_en_s     = 1'b1;
               count_nxt_s = count_r + CW'(1);
            end
         end
         2'b01: begin
            if (empty_s) begin
               unf_set_s = 1'b1;
            end else begin
               rd_en_s     = 1'b1;
               count_nxt_s = cm1_s;
            end
         end
         2'b00: begin
            if (tos) begin
               if (empty_s) begin
                  unf_set_s = 1'b1;
               end else begin
                  rd_en_s = 1'b1;
               end
            end else begin
               rd_en_s = 1'b0;
            end
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
   end

   // Control state, read register and sticky flags (set wins over clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r    <= '0;
         dout_r     <= '0;
         dout_vld_r <= 1'b0;
         ovf_r      <= 1'b0;
         unf_r      <= 1'b0;
      end else begin
         count_r    <= count_nxt_s;
         dout_vld_r <= rd_en_s;
         if (rd_en_s) begin
            dout_r <= rd_data_s;
         end
         ovf_r <= ovf_set_s | (ovf_r & ~err_clr);
         unf_r <= unf_set_s | (unf_r & ~err_clr);
      end
   end

   // Storage array is not reset; writes are blocked while rst is high
   always_ff @(posedge clk) begin
      if (wr_en_s && !rst) begin
         mem_r[wr_idx_s] <= din;
      end
   end

   assign dout     = dout_r;
   assign dout_vld = dout_vld_r;
   assign count    = count_r;
   assign empty    = empty_s;
   assign full     = full_s;
   assign ovf      = ovf_r;
   assign unf      = unf_r;

endmodule

// File: tb/tb_param_stack.sv
// Randomized scoreboard bench for param_stack: queue-based reference stack,
// directed corner sequences, async reset, and a WIDTH=16/DEPTH=5 instance.
module tb_param_stack;

   localparam int DA = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
   logic [7:0] dout;
   logic       dout_vld, empty, full, ovf, unf;
   logic [5:0] count;

   logic [15:0] b_din = 16'h0000;
   logic        b_push = 1'b0, b_pop = 1'b0;
   logic [15:0] b_dout;
   logic        b_vld, b_empty, b_full, b_ovf, b_unf;
   logic [2:0]  b_count;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: value after the next rising edge
   logic [7:0] stk[$];
   logic [7:0] exp_q[$];
   logic [7:0] m_dout = 8'h00;
   logic       m_vld = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

   always #5 clk = ~clk;

   param_stack #(.WIDTH(8), .DEPTH(DA)) dut_a (
      .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .tos(tos),
      .err_clr(err_clr), .dout(dout), .dout_vld(dout_vld), .count(count),
      .empty(empty), .full(full), .ovf(ovf), .unf(unf));

   param_stack #(.WIDTH(16), .DEPTH(5)) dut_b (
      .clk(clk), .rst(rst), .din(b_din), .push(b_push), .pop(b_pop), .tos(1'b0),
      .err_clr(1'b0), .dout(b_dout), .dout_vld(b_vld), .count(b_count),
      .empty(b_empty), .full(b_full), .ovf(b_ovf), .unf(b_unf));

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // drive one command for the coming edge and advance the model
   task automatic step(input logic p, input logic q, input logic t, input logic c,
                       input logic [7:0] d);
      logic ovf_set, unf_set;
      @(negedge clk);
      push = p; pop = q; tos = t; err_clr = c; din = d;
      ovf_set = 1'b0; unf_set = 1'b0; m_vld = 1'b0;
      if (p && q) begin
         if (stk.size() > 0) begin
            m_dout = stk.pop_back();
            m_vld  = 1'b1;
         end
         stk.push_back(d);
      end else if (p) begin
         if (stk.size() < DA) stk.push_back(d);
         else ovf_set = 1'b1;
      end else if (q) begin
         if (stk.size() > 0) begin
            m_dout = stk.pop_back();
            m_vld  = 1'b1;
         end else unf_set = 1'b1;
      end else if (t) begin
         if (stk.size() > 0) begin
            m_dout = stk[$];
            m_vld  = 1'b1;
         end else unf_set = 1'b1;
      end
      m_ovf = ovf_set | (m_ovf & ~c);
      m_unf = unf_set | (m_unf & ~c);
      if (m_vld) exp_q.push_back(m_dout);
   endtask

   // monitor: pops the scoreboard whenever the DUT presents read data
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (dout_vld) begin
            if (exp_q.size() == 0) begin
               chk("spurious_vld", 1, 0);
            end else begin
               chk("dout", int'(dout), int'(exp_q.pop_front()));
            end
         end else begin
            chk("dout_hold", int'(dout), int'(m_dout));
         end
         chk("dout_vld", int'(dout_vld), int'(m_vld));
         chk("count", int'(count), stk.size());
         chk("empty", int'(empty), int'(stk.size() == 0));
         chk("full", int'(full), int'(stk.size() == DA));
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("unf", int'(unf), int'(m_unf));
      end
   end

   task automatic b_cyc(input logic p, input logic q, input logic [15:0] d);
      @(negedge clk);
      b_push = p; b_pop = q; b_din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_vld", int'(dout_vld), 0);
      chk("rst_flags", int'({ovf, unf}), 0);
      @(negedge clk);
      rst = 1'b0;

      // empty-stack underflow, then clear
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      // basic LIFO order
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      // replace top, then peek
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      // push+pop on empty acts as push, tos ignored under push
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h44);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      // fill, overflow, replace while full, drain
      for (int i = 0; i < DA; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'hBB);
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'hCC);
      for (int i = 0; i < DA + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);

      // async reset between edges
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_dout", int'(dout), 0);
      push = 1'b1; din = 8'h55;
      stk.delete(); exp_q.delete();
      m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      rst = 1'b0; push = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // randomized traffic with alternating fill/drain bias
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = ((i / 150) % 2 == 0) ? 70 : 30;
         step(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
              8'($urandom));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("sb_drained", exp_q.size(), 0);

      // WIDTH=16, DEPTH=5 instance: fill, overflow, drain
      for (int i = 0; i < 5; i++) begin
         b_cyc(1'b1, 1'b0, 16'h1000 + 16'(i * 16'h0111));
         chk("b_count_fill", int'(b_count), i + 1);
      end
      chk("b_full", int'(b_full), 1);
      b_cyc(1'b1, 1'b0, 16'hAAAA);
      chk("b_ovf", int'(b_ovf), 1);
      chk("b_count_max", int'(b_count), 5);
      for (int i = 4; i >= 0; i--) begin
         b_cyc(1'b0, 1'b1, 16'h0000);
         chk("b_vld", int'(b_vld), 1);
         chk("b_dout", int'(b_dout), 16'h1000 + i * 16'h0111);
      end
      chk("b_empty", int'(b_empty), 1);
      b_cyc(1'b0, 1'b1, 16'h0000);
      chk("b_unf", int'(b_unf), 1);
      chk("b_vld_empty", int'(b_vld), 0);
      b_cyc(1'b0, 1'b0, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
